// File: rtl/fp_div_result_stage.sv
// Result stage of the single-precision FP divider: special-case resolution, exponent
// range check, exception flags and a valid/ready output FIFO. Optional: FP_DIV_STICKY_FLAGS_EN.
`timescale 1ns/1ps
module fp_div_result_stage #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] InA,
  input  logic [31:0] InB,
  input  logic [31:0] DivOut,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] Out,
  output logic [3:0]  Flags
`ifdef FP_DIV_STICKY_FLAGS_EN
  ,
  input  logic        FlagClr,
  output logic [3:0]  StickyFlags
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [35:0]      mem [DEPTH];

  logic        push, pop;
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        sign;
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [9:0]  e_full;
  logic        e_ovf, e_unf;
  logic [31:0] result;
  logic [3:0]  flags_new;
  logic        unused_div_bits;

  assign unused_div_bits = ^DivOut[31:23];

  assign ea   = InA[30:23];
  assign eb   = InB[30:23];
  assign ma   = InA[22:0];
  assign mb   = InB[22:0];
  assign sign = InA[31] ^ InB[31];

  // Denormals are flushed to zero: a zero exponent alone classifies as zero.
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (ma == '0);
  assign b_inf  = (eb == 8'hFF) && (mb == '0);
  assign a_nan  = (ea == 8'hFF) && (ma != '0);
  assign b_nan  = (eb == 8'hFF) && (mb != '0);

  // Two's complement 10-bit exponent; bit 9 set means negative.
  assign e_full = {2'b00, ea} - {2'b00, eb} + 10'd127 - {9'd0, (ma < mb)};
  assign e_ovf  = !e_full[9] && (e_full >= 10'd255);
  assign e_unf  = e_full[9] || (e_full == 10'd0);

  always_comb begin
    result    = '0;
    flags_new = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      result    = QNAN;
      flags_new = 4'b1000;
    end else if (a_inf) begin
      result = {sign, 8'hFF, 23'd0};
    end else if (b_zero) begin
      result    = {sign, 8'hFF, 23'd0};
      flags_new = 4'b0100;
    end else if (a_zero || b_inf) begin
      result = {sign, 31'd0};
    end else if (e_ovf) begin
      result    = {sign, 8'hFF, 23'd0};
      flags_new = 4'b0010;
    end else if (e_unf) begin
      result    = {sign, 31'd0};
      flags_new = 4'b0001;
    end else begin
      result = {sign, e_full[7:0], DivOut[22:0]};
    end
  end

  assign InReady  = (count < FULL_COUNT);
  assign OutValid = (count != '0);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is zero.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= {flags_new, result};
  end

  assign Out   = OutValid ? mem[rd_ptr][31:0]  : '0;
  assign Flags = OutValid ? mem[rd_ptr][35:32] : '0;

`ifdef FP_DIV_STICKY_FLAGS_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      StickyFlags <= '0;
    end else if (push) begin
      StickyFlags <= (FlagClr ? 4'b0000 : StickyFlags) | flags_new;
    end else if (FlagClr) begin
      StickyFlags <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fp_div_result_stage.sv
// Directed self-checking bench for fp_div_result_stage (classification, FIFO flow, reset).
`timescale 1ns/1ps
module tb_fp_div_result_stage;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        InValid;
  logic        InReady;
  logic [31:0] InA, InB, DivOut;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Out;
  logic [3:0]  Flags;
`ifdef FP_DIV_STICKY_FLAGS_EN
  logic        FlagClr;
  logic [3:0]  StickyFlags;
`endif

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic [31:0] o;
    logic [3:0]  f;
  } vec_t;

  always #5 Clk = ~Clk;

  fp_div_result_stage #(.DEPTH(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
    .InA(InA), .InB(InB), .DivOut(DivOut), .OutValid(OutValid),
    .OutReady(OutReady), .Out(Out), .Flags(Flags)
`ifdef FP_DIV_STICKY_FLAGS_EN
    , .FlagClr(FlagClr), .StickyFlags(StickyFlags)
`endif
  );

  task automatic push_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
    @(negedge Clk);
    InA = a; InB = b; DivOut = d; InValid = 1'b1;
    @(posedge Clk);
    #1 InValid = 1'b0;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    InA = '0; InB = '0; DivOut = '0;
`ifdef FP_DIV_STICKY_FLAGS_EN
    FlagClr = 1'b0;
`endif
    #12;
    n_cmp++;
    if ({OutValid, InReady, Out, Flags} !== {1'b0, 1'b1, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_state: OutValid=%b InReady=%b Out=%h Flags=%b expected 0 1 00000000 0000",
               OutValid, InReady, Out, Flags);
    end
    @(negedge Clk) Reset_n = 1'b1;
  endtask

  task automatic test_classification;
    vec_t v [$];
    v.push_back({32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 4'b0000});
    v.push_back({32'h3F800000, 32'h00000000, 32'h00000000, 32'h7F800000, 4'b0100});
    v.push_back({32'hBF800000, 32'h00000000, 32'h00000000, 32'hFF800000, 4'b0100});
    v.push_back({32'h00000000, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000});
    v.push_back({32'h7F800000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000});
    v.push_back({32'h7FC00001, 32'h3F800000, 32'h00000000, 32'h7FC00000, 4'b1000});
    v.push_back({32'h7FC00000, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000});
    v.push_back({32'h7F000000, 32'h00800001, 32'h00000000, 32'h7F800000, 4'b0010});
    v.push_back({32'h00800000, 32'h7F000000, 32'h00000000, 32'h00000000, 4'b0001});
    v.push_back({32'h7F800000, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0000});
    v.push_back({32'h7F800000, 32'h00000000, 32'h00000000, 32'h7F800000, 4'b0000});
    v.push_back({32'h80000000, 32'h3F800000, 32'h00000000, 32'h80000000, 4'b0000});
    v.push_back({32'h00000001, 32'h3F800000, 32'h00000000, 32'h00000000, 4'b0000});
    v.push_back({32'h3F800000, 32'hFF800000, 32'h00000000, 32'h80000000, 4'b0000});
    v.push_back({32'h00000000, 32'h7F800000, 32'h00000000, 32'h00000000, 4'b0000});
    v.push_back({32'h7F000000, 32'h3F800000, 32'h00123456, 32'h7F123456, 4'b0000});
    v.push_back({32'h7F000000, 32'h3F000000, 32'h00000000, 32'h7F800000, 4'b0010});
    v.push_back({32'h00800000, 32'h3F800000, 32'hFF000000, 32'h00800000, 4'b0000});
    v.push_back({32'h00800000, 32'h3F800001, 32'h00000000, 32'h00000000, 4'b0001});
    v.push_back({32'hC0C00000, 32'h40000000, 32'h00400000, 32'hC0400000, 4'b0000});
    OutReady = 1'b1;
    foreach (v[i]) begin
      push_one(v[i].a, v[i].b, v[i].d);
      n_cmp++;
      if ({OutValid, Out, Flags} !== {1'b1, v[i].o, v[i].f}) begin
        n_fail++;
        $display("FAIL classify[%0d] A=%h B=%h: OutValid=%b Out=%h Flags=%b expected 1 %h %b",
                 i, v[i].a, v[i].b, OutValid, Out, Flags, v[i].o, v[i].f);
      end
    end
    @(posedge Clk); #1;
    n_cmp++;
    if ({OutValid, Out, Flags} !== {1'b0, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL classify_drain: OutValid=%b Out=%h Flags=%b expected 0 00000000 0000",
               OutValid, Out, Flags);
    end
    OutReady = 1'b0;
  endtask

  task automatic test_back_to_back;
    OutReady = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push_one(32'h3F800000, 32'h3F800000, 32'(k));
      n_cmp++;
      if (InReady !== (k < 4)) begin
        n_fail++;
        $display("FAIL fill_inready[%0d]: InReady=%b expected %b", k, InReady, (k < 4));
      end
    end
    push_one(32'h3F800000, 32'h3F800000, 32'd5);
    n_cmp++;
    if ({InReady, OutValid, Out} !== {1'b0, 1'b1, 32'h3F800001}) begin
      n_fail++;
      $display("FAIL full_blocks_push: InReady=%b OutValid=%b Out=%h expected 0 1 3f800001",
               InReady, OutValid, Out);
    end
    @(negedge Clk) OutReady = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if ({OutValid, Out, Flags} !== {1'b1, 32'h3F800000 | 32'(k), 4'h0}) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: OutValid=%b Out=%h Flags=%b expected 1 %h 0000",
                 k, OutValid, Out, Flags, 32'h3F800000 | 32'(k));
      end
      @(negedge Clk);
    end
    n_cmp++;
    if ({OutValid, InReady, Out} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL drain_empty: OutValid=%b InReady=%b Out=%h expected 0 1 00000000",
               OutValid, InReady, Out);
    end
    OutReady = 1'b0;
    push_one(32'h3F800000, 32'h3F800000, 32'd6);
    @(negedge Clk);
    InA = 32'h3F800000; InB = 32'h3F800000; DivOut = 32'd7; InValid = 1'b1; OutReady = 1'b1;
    @(posedge Clk); #1 InValid = 1'b0;
    n_cmp++;
    if ({OutValid, InReady, Out} !== {1'b1, 1'b1, 32'h3F800007}) begin
      n_fail++;
      $display("FAIL push_pop_same_cycle: OutValid=%b InReady=%b Out=%h expected 1 1 3f800007",
               OutValid, InReady, Out);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL push_pop_count: OutValid=%b expected 0", OutValid);
    end
    OutReady = 1'b0;
  endtask

  task automatic test_reset_midstream;
    OutReady = 1'b0;
    for (int k = 1; k <= 3; k++) push_one(32'h40000000, 32'h3F800000, 32'(k));
    @(negedge Clk); #2 Reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({OutValid, InReady, Out, Flags} !== {1'b0, 1'b1, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_midstream: OutValid=%b InReady=%b Out=%h Flags=%b expected 0 1 00000000 0000",
               OutValid, InReady, Out, Flags);
    end
    @(negedge Clk) Reset_n = 1'b1;
    push_one(32'h40C00000, 32'h40000000, 32'h40400000);
    n_cmp++;
    if ({OutValid, Out} !== {1'b1, 32'h40400000}) begin
      n_fail++;
      $display("FAIL post_reset_head: OutValid=%b Out=%h expected 1 40400000", OutValid, Out);
    end
    @(negedge Clk) OutReady = 1'b1;
    @(posedge Clk); #1;
    n_cmp++;
    if ({OutValid, Out} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL post_reset_alone: OutValid=%b Out=%h expected 0 00000000", OutValid, Out);
    end
    OutReady = 1'b0;
  endtask

`ifdef FP_DIV_STICKY_FLAGS_EN
  task automatic test_sticky;
    OutReady = 1'b1;
    push_one(32'h3F800000, 32'h00000000, 32'h0);
    push_one(32'h7F000000, 32'h00800001, 32'h0);
    n_cmp++;
    if (StickyFlags !== 4'b0110) begin
      n_fail++;
      $display("FAIL sticky_accum: StickyFlags=%b expected 0110", StickyFlags);
    end
    @(negedge Clk);
    InA = 32'h00000000; InB = 32'h00000000; InValid = 1'b1; FlagClr = 1'b1;
    @(posedge Clk); #1 InValid = 1'b0; FlagClr = 1'b0;
    n_cmp++;
    if (StickyFlags !== 4'b1000) begin
      n_fail++;
      $display("FAIL sticky_clr_push: StickyFlags=%b expected 1000", StickyFlags);
    end
    @(negedge Clk) FlagClr = 1'b1;
    @(posedge Clk); #1 FlagClr = 1'b0;
    n_cmp++;
    if (StickyFlags !== 4'b0000) begin
      n_fail++;
      $display("FAIL sticky_clr: StickyFlags=%b expected 0000", StickyFlags);
    end
    OutReady = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_classification;
    test_back_to_back;
    test_reset_midstream;
`ifdef FP_DIV_STICKY_FLAGS_EN
    test_sticky;
`endif
    repeat (2) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
